// File: rtl/debounce_pkg.sv
// Shared constants for the push-button debouncers: board clock, default
// filter thresholds and the idle pin level of the console buttons.
package debounce_pkg;

  localparam int unsigned CLK_HZ         = 50_000_000;
  localparam int unsigned DB_PRESS_CYC   = 50_000;
  localparam int unsigned DB_RELEASE_CYC = 501;
  localparam int unsigned DB_LONG_CYC    = CLK_HZ;

  // Board buttons pull up and short to ground when pressed.
  localparam bit   DB_ACTIVE_LOW  = 1'b1;
  localparam logic BTN_IDLE_LEVEL = 1'b1;

  function automatic int unsigned umax(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // Pin level seen while a button is not pressed.
  function automatic logic idle_level(input bit active_low);
    return active_low ? BTN_IDLE_LEVEL : ~BTN_IDLE_LEVEL;
  endfunction

endpackage

// File: rtl/debounce_multi_if.sv
// Button bank bundle: raw pins in, debounced level and event strobes out.
interface debounce_multi_if #(
  parameter int unsigned N_CH = 4
);

  logic [N_CH-1:0] btn_in;
  logic [N_CH-1:0] btn_level;
  logic [N_CH-1:0] btn_press;
  logic [N_CH-1:0] btn_release;
  logic [N_CH-1:0] btn_long;

  // master drives the pins (board / bench), slave is the debouncer
  modport master (
    output btn_in,
    input  btn_level, btn_press, btn_release, btn_long
  );

  modport slave (
    input  btn_in,
    output btn_level, btn_press, btn_release, btn_long
  );

endinterface

// File: rtl/debounce_ch.sv
// Single-channel debouncer: 2-FF synchroniser, asymmetric stability filter,
// level + press/release strobes; long-press strobe under DEBOUNCE_LONGPRESS_EN.
module debounce_ch
  import debounce_pkg::*;
#(
  parameter int unsigned COUNT_PRESS   = DB_PRESS_CYC,
  parameter int unsigned COUNT_RELEASE = DB_RELEASE_CYC,
  parameter int unsigned COUNT_LONG    = DB_LONG_CYC,
  parameter bit          ACTIVE_LOW    = DB_ACTIVE_LOW
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_in,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release,
  output logic btn_long
);

  localparam int unsigned CW   = $clog2(umax(COUNT_PRESS, COUNT_RELEASE) + 1);
  localparam logic        IDLE = idle_level(ACTIVE_LOW);

  logic          sync1;
  logic          sync2;
  logic          raw_p;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= IDLE;
      sync2 <= IDLE;
    end else begin
      sync1 <= btn_in;
      sync2 <= sync1;
    end
  end

  assign raw_p = sync2 ^ ACTIVE_LOW;

  // Any sample agreeing with the current level throws away the whole run.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt         <= '0;
      btn_level   <= 1'b0;
      btn_press   <= 1'b0;
      btn_release <= 1'b0;
    end else begin
      btn_press   <= 1'b0;
      btn_release <= 1'b0;
      if (raw_p == btn_level) begin
        cnt <= '0;
      end else if (raw_p && (cnt == CW'(COUNT_PRESS - 1))) begin
        cnt       <= '0;
        btn_level <= 1'b1;
        btn_press <= 1'b1;
      end else if (!raw_p && (cnt == CW'(COUNT_RELEASE - 1))) begin
        cnt         <= '0;
        btn_level   <= 1'b0;
        btn_release <= 1'b1;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

`ifdef DEBOUNCE_LONGPRESS_EN
  localparam int unsigned HW = $clog2(COUNT_LONG + 1);

  logic [HW-1:0] hold;

  // Saturating hold timer; reaching the limit fires exactly once per press.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold     <= '0;
      btn_long <= 1'b0;
    end else begin
      btn_long <= 1'b0;
      if (!btn_level) begin
        hold <= '0;
      end else if (hold != HW'(COUNT_LONG)) begin
        hold <= hold + HW'(1);
        if (hold == HW'(COUNT_LONG - 1)) begin
          btn_long <= 1'b1;
        end
      end
    end
  end
`else
  logic unused_long_cfg;

  assign unused_long_cfg = ^COUNT_LONG;
  assign btn_long        = 1'b0;
`endif

endmodule

// File: rtl/debounce_multi.sv
// N-channel push-button debouncer for the console button bank; one
// debounce_ch per pin. Long-press strobes need DEBOUNCE_LONGPRESS_EN.
module debounce_multi
  import debounce_pkg::*;
#(
  parameter int unsigned N_CH          = 4,
  parameter int unsigned COUNT_PRESS   = DB_PRESS_CYC,
  parameter int unsigned COUNT_RELEASE = DB_RELEASE_CYC,
  parameter int unsigned COUNT_LONG    = DB_LONG_CYC,
  parameter bit          ACTIVE_LOW    = DB_ACTIVE_LOW
) (
  input  logic             clk,
  input  logic             reset,
  debounce_multi_if.slave  bus
);

  logic [N_CH-1:0] level;
  logic [N_CH-1:0] press;
  logic [N_CH-1:0] rel;
  logic [N_CH-1:0] lng;

  for (genvar i = 0; i < int'(N_CH); i++) begin : g_ch
    debounce_ch #(
      .COUNT_PRESS   (COUNT_PRESS),
      .COUNT_RELEASE (COUNT_RELEASE),
      .COUNT_LONG    (COUNT_LONG),
      .ACTIVE_LOW    (ACTIVE_LOW)
    ) u_ch (
      .clk         (clk),
      .reset       (reset),
      .btn_in      (bus.btn_in[i]),
      .btn_level   (level[i]),
      .btn_press   (press[i]),
      .btn_release (rel[i]),
      .btn_long    (lng[i])
    );
  end

  assign bus.btn_level   = level;
  assign bus.btn_press   = press;
  assign bus.btn_release = rel;
  assign bus.btn_long    = lng;

endmodule

// File: tb/tb_debounce_multi.sv
// Bench for debounce_multi: directed timing cases plus random pin activity,
// checked every cycle against a sample-window model of the filter.
module tb_debounce_multi;

  localparam int unsigned N  = 2;
  localparam int unsigned CP = 8;
  localparam int unsigned CR = 3;
  localparam int unsigned CL = 20;
  localparam bit          AL = 1'b1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  debounce_multi_if #(.N_CH(N)) bus ();

  debounce_multi #(
    .N_CH          (N),
    .COUNT_PRESS   (CP),
    .COUNT_RELEASE (CR),
    .COUNT_LONG    (CL),
    .ACTIVE_LOW    (AL)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  // Model: last CP pressed-samples per channel, pin delay line, level, strobes.
  logic [CP-1:0] win [N];
  bit            dly1 [N];
  bit            dly2 [N];
  bit            lvl  [N];
  bit            e_press [N];
  bit            e_rel   [N];
  bit            e_long  [N];
  int            pedge   [N];
  int            g = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < int'(N); c++) begin
      win[c]     = '0;
      dly1[c]    = AL;
      dly2[c]    = AL;
      lvl[c]     = 1'b0;
      e_press[c] = 1'b0;
      e_rel[c]   = 1'b0;
      e_long[c]  = 1'b0;
      pedge[c]   = 0;
    end
  endtask

  // Level flips once the last CP (or CR) samples all disagree with it.
  task automatic model_step();
    g++;
    if (!reset) begin
      model_reset();
      return;
    end
    for (int c = 0; c < int'(N); c++) begin
      bit raw;
      raw     = dly2[c];
      dly2[c] = dly1[c];
      dly1[c] = bus.btn_in[c];
      win[c]  = {win[c][CP-2:0], (raw != AL)};
      e_press[c] = !lvl[c] && (&win[c]);
      e_rel[c]   = lvl[c] && (win[c][CR-1:0] == '0);
`ifdef DEBOUNCE_LONGPRESS_EN
      e_long[c]  = lvl[c] && ((g - pedge[c]) == int'(CL));
`else
      e_long[c]  = 1'b0;
`endif
      if (e_press[c]) begin
        lvl[c]   = 1'b1;
        pedge[c] = g;
      end
      if (e_rel[c]) lvl[c] = 1'b0;
    end
  endtask

  task automatic compare();
    for (int c = 0; c < int'(N); c++) begin
      chk($sformatf("level[%0d]", c),   32'(bus.btn_level[c]),   32'(lvl[c]));
      chk($sformatf("press[%0d]", c),   32'(bus.btn_press[c]),   32'(e_press[c]));
      chk($sformatf("release[%0d]", c), 32'(bus.btn_release[c]), 32'(e_rel[c]));
      chk($sformatf("long[%0d]", c),    32'(bus.btn_long[c]),    32'(e_long[c]));
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    compare();
  endtask

  // Edges until the chosen strobe (0 press, 1 release); n == bound on timeout.
  task automatic wait_ev(input int ch, input int kind, input int bound, output int n);
    n = 0;
    while (n < bound) begin
      step();
      n++;
      if (kind == 0 && bus.btn_press[ch] === 1'b1) return;
      if (kind == 1 && bus.btn_release[ch] === 1'b1) return;
    end
    n = bound;
  endtask

  task automatic do_reset();
    bus.btn_in = {N{AL}};
    reset = 1'b0;
    model_reset();
    repeat (2) step();
    reset = 1'b1;
    repeat (3) step();
  endtask

  task automatic async_reset_check(input string nm);
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    chk({nm, "_level"},   32'(bus.btn_level),   32'd0);
    chk({nm, "_press"},   32'(bus.btn_press),   32'd0);
    chk({nm, "_release"}, 32'(bus.btn_release), 32'd0);
    chk({nm, "_long"},    32'(bus.btn_long),    32'd0);
  endtask

  initial begin
    int n, cnt, p0, p1, lf, lc;
    reset = 1'b0;
    bus.btn_in = {N{AL}};
    model_reset();
    #1;
    chk("reset_outputs", 32'({bus.btn_level, bus.btn_press, bus.btn_release, bus.btn_long}), 32'd0);

    // Clean press and release
    do_reset();
    bus.btn_in[0] = 1'b0;
    wait_ev(0, 0, 40, n);
    chk("clean_press_edge", 32'(n), 32'd10);
    step();
    chk("press_one_cycle", 32'(bus.btn_press[0]), 32'd0);
    bus.btn_in[0] = 1'b1;
    wait_ev(0, 1, 40, n);
    chk("release_edge", 32'(n), 32'd5);
    repeat (4) step();

    // Bounce: low 7, high 1, then steady low
    bus.btn_in[0] = 1'b0;
    cnt = 0;
    repeat (7) begin step(); cnt += int'(bus.btn_press[0]); end
    bus.btn_in[0] = 1'b1;
    step();
    cnt += int'(bus.btn_press[0]);
    bus.btn_in[0] = 1'b0;
    wait_ev(0, 0, 40, n);
    chk("bounce_no_press", 32'(cnt), 32'd0);
    chk("bounce_press_edge", 32'(n), 32'd10);

    // Two-cycle high glitch while pressed
    bus.btn_in[0] = 1'b1;
    cnt = 0;
    repeat (2) step();
    bus.btn_in[0] = 1'b0;
    repeat (15) begin step(); cnt += int'(bus.btn_release[0]); end
    chk("glitch_no_release", 32'(cnt), 32'd0);
    chk("glitch_level_held", 32'(bus.btn_level[0]), 32'd1);

    // Long press on ch1
    do_reset();
    bus.btn_in[1] = 1'b0;
    p1 = -1; lf = -1; lc = 0;
    for (int i = 1; i <= 60; i++) begin
      step();
      if (bus.btn_press[1] && p1 < 0) p1 = i;
      if (bus.btn_long[1]) begin
        lc++;
        if (lf < 0) lf = i;
      end
    end
    chk("long_press_edge", 32'(p1), 32'd10);
`ifdef DEBOUNCE_LONGPRESS_EN
    chk("long_edge", 32'(lf), 32'd30);
    chk("long_count", 32'(lc), 32'd1);
`else
    chk("long_count", 32'(lc), 32'd0);
`endif

    // Independence: ch0 at cycle 0, ch1 at cycle 3
    do_reset();
    p0 = -1; p1 = -1;
    bus.btn_in[0] = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (i == 3) bus.btn_in[1] = 1'b0;
      if (bus.btn_press[0] && p0 < 0) p0 = i;
      if (bus.btn_press[1] && p1 < 0) p1 = i;
    end
    chk("indep_press0", 32'(p0), 32'd10);
    chk("indep_press1", 32'(p1), 32'd13);

    // Async reset mid-count, pin still low on release
    do_reset();
    bus.btn_in[0] = 1'b0;
    repeat (7) step();
    chk("pre_reset_level", 32'(bus.btn_level[0]), 32'd0);
    async_reset_check("async_rst");
    repeat (2) step();
    #2;
    reset = 1'b1;
    wait_ev(0, 0, 40, n);
    chk("post_reset_press_edge", 32'(n), 32'd10);

    // Random pin activity with occasional async resets
    do_reset();
    begin
      int dur [N];
      for (int c = 0; c < int'(N); c++) dur[c] = 1;
      for (int i = 0; i < 3000; i++) begin
        for (int c = 0; c < int'(N); c++) begin
          dur[c]--;
          if (dur[c] <= 0) begin
            bus.btn_in[c] = ~bus.btn_in[c];
            dur[c] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(15, 45))
                                                 : int'($urandom_range(1, 12));
          end
        end
        if ($urandom_range(0, 499) == 0) begin
          async_reset_check("rand_async_rst");
          repeat (2) step();
          #2;
          reset = 1'b1;
        end else begin
          step();
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
